// File: rtl/seq_det_ctrl.sv
// Sequencing controller for a serial 1011 pattern detector: accepts parallel
// words, arms the detector and shifts each word MSB-first, reporting per-word match results.
module seq_det_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [DATA_W-1:0]         word_i,
    input  logic                      word_valid_i,
    output logic                      word_ready_o,
    output logic                      det_start_o,
    output logic                      det_serial_o,
    input  logic                      det_detected_i,
    output logic                      done_o,
    output logic                      found_o,
    output logic [$clog2(DATA_W)-1:0] pos_o,
    output logic [CNT_W-1:0]          match_cnt_o,
    input  logic                      clr_cnt_i
);

    localparam int POS_W = $clog2(DATA_W);
    localparam int BCW   = POS_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_FLUSH = 3'd2,
        S_SHIFT = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q;
    logic [BCW-1:0]      bit_cnt_q;
    logic                flush_cnt_q;
    logic                armed_q;
    logic                found_q;
    logic [POS_W-1:0]    pos_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept;
    logic                hit;

    assign accept = word_valid_i && word_ready_o;
    assign hit    = det_detected_i && (state_q == S_SHIFT || state_q == S_DRAIN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: each always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = armed_q ? S_FLUSH : S_START;
            S_START: state_d = S_SHIFT;
            S_FLUSH: if (flush_cnt_q) state_d = S_SHIFT;
            S_SHIFT: begin
                if (det_detected_i)                       state_d = S_DONE;
                else if (bit_cnt_q == BCW'(DATA_W - 1))   state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        word_ready_o = 1'b0;
        det_start_o  = 1'b0;
        det_serial_o = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            S_IDLE:  word_ready_o = 1'b1;
            S_START: det_start_o  = 1'b1;
            S_SHIFT: det_serial_o = shreg_q[DATA_W-1];
            S_DONE:  done_o       = 1'b1;
            default: ;
        endcase
    end

    // Result registers are written on the edge into DONE so they become visible with done_o.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            flush_cnt_q <= 1'b0;
            armed_q     <= 1'b0;
            found_q     <= 1'b0;
            pos_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) shreg_q <= word_i;
                    bit_cnt_q   <= '0;
                    flush_cnt_q <= 1'b0;
                end
                S_START: armed_q     <= 1'b1;
                S_FLUSH: flush_cnt_q <= ~flush_cnt_q;
                S_SHIFT: begin
                    shreg_q   <= shreg_q << 1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (det_detected_i) begin
                        found_q <= 1'b1;
                        pos_q   <= POS_W'(bit_cnt_q - 1'b1);
                        armed_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (det_detected_i) begin
                        found_q <= 1'b1;
                        pos_q   <= POS_W'(DATA_W - 1);
                        armed_q <= 1'b0;
                    end else begin
                        found_q <= 1'b0;
                        pos_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear takes priority over a same-cycle increment; increments stop at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)                   cnt_q <= '0;
        else if (clr_cnt_i)            cnt_q <= '0;
        else if (hit && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
    end

    assign found_o     = found_q;
    assign pos_o       = pos_q;
    assign match_cnt_o = cnt_q;

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Sequencing controller for the serial 1011 pattern detector. It accepts parallel words over a valid/ready handshake, arms the detector, and shifts each word MSB-first onto the detector's serial input. It watches the detector's detect flag and reports per word whether a match occurred and at which bit. It also keeps a saturating match count.

Parameters:
DATA_W, 16, width of the parallel word; min 2.
CNT_W, 8, width of the saturating match counter.

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, synchronous active-low; shared with the detector
word_i  in  DATA_W  parallel word to scan
word_valid_i  in  1  word_i valid
word_ready_o  out  1  controller can accept a word
det_start_o  out  1  start pulse to detector
det_serial_o  out  1  serial bit to detector
det_detected_i  in  1  detector match flag
done_o  out  1  one-cycle pulse: result for the current word is valid
found_o  out  1  a match occurred in the word; held until the next done_o
pos_o  out  $clog2(DATA_W)  bit index (0 = MSB, first bit shifted) of the last pattern bit; held
match_cnt_o  out  CNT_W  total matches, saturating
clr_cnt_i  in  1  synchronous clear of match_cnt_o

Behaviour:
- Detector contract:
  - Honours start only while idle; start moves it to waiting.
  - Samples one serial bit per cycle.
  - det_detected_i is high in the cycle after the final pattern bit is sampled. The detector then returns to idle and needs a new start.
  - Without a match it never returns to idle. Two serial 0s always leave it waiting.
- Reset (rstn_i low at a clock edge): state=IDLE, armed=0. Outputs: word_ready_o=1, det_start_o=0, det_serial_o=0, done_o=0, found_o=0, pos_o=0, match_cnt_o=0. Reset mid-word abandons the word with no done_o.
- armed flag: set on leaving START; cleared when det_detected_i is seen.
- IDLE:
  - word_ready_o=1.
  - On word_valid_i & word_ready_o: load the shift register, bit_cnt=0.
  - Next state is START if armed=0, else FLUSH.
  - word_ready_o=0 in every other state.
- START: det_start_o=1 for exactly 1 cycle, det_serial_o=0, then SHIFT.
- FLUSH: det_serial_o=0 for exactly 2 cycles, then SHIFT. No start issued. This prevents partial matches from carrying across words.
- SHIFT:
  - det_serial_o = shreg[DATA_W-1]; shift left by 1 each cycle; bit_cnt++.
  - If det_detected_i: found=1, pos=bit_cnt-1, armed=0, then DONE. Remaining bits are discarded.
  - Else if bit_cnt==DATA_W-1 (last bit driven): go to DRAIN.
- DRAIN:
  - det_serial_o=0.
  - If det_detected_i: found=1, pos=DATA_W-1, armed=0. Otherwise found=0, pos=0.
  - Then DONE.
- DONE: done_o=1 for 1 cycle; found_o/pos_o update this cycle; then IDLE.
- Latency (handshake in cycle t, armed=0):
  - No match: done_o in cycle t+DATA_W+3.
  - Match ending at bit k: done_o in cycle t+k+4.
  - FLUSH path adds 1 cycle.
- Counter:
  - match_cnt_o += 1 on each det_detected_i seen in SHIFT or DRAIN; saturates at 2^CNT_W-1.
  - If clr_cnt_i and an increment occur in the same cycle, the counter goes to 0 (clear wins).
- det_detected_i outside SHIFT/DRAIN is ignored and cannot occur in legal operation.
- At most one match is reported per word.
- States are encoded in 3 bits; unused encodings go to IDLE.

Test Plan:
1. Reset, then word 16'hB000 -> det_start_o pulses 1 cycle after handshake; det_serial_o shows 1,0,1,1. det_detected_i is high at bit_cnt=4. done_o at t+7 with found_o=1, pos_o=3, match_cnt_o=1.
2. Word 16'h000B (armed=0) -> match on the last bit, seen in DRAIN. done_o at t+19 with found_o=1, pos_o=15.
3. Word 16'h0000 -> done_o at t+19 with found_o=0, pos_o=0. armed stays 1.
4. Word 16'h0002 then 16'hC000 (second word takes the FLUSH path, no start) -> found_o=0 for both; the cross-word 1011 is not detected.
5. Force match_cnt_o to 255 and scan 16'hB000 -> count stays 255. Assert clr_cnt_i in the cycle of a detect -> count becomes 0.
6. rstn_i low for 1 cycle during SHIFT -> next cycle all outputs at reset values, word_ready_o=1, no done_o. The next word uses the START path.
